// File: rtl/acq_run_ctrl.sv
// rtl/acq_run_ctrl.sv - acquisition run controller: arm, framed run, drain, done
module acq_run_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ARM_CYCLES = 4
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] frame_period,
    input  logic [DATA_WIDTH-1:0] n_frames,
    input  logic                  sink_idle,
    output logic                  acq_enable,
    output logic                  frame_start,
    output logic [DATA_WIDTH-1:0] frame_index,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    state_t                st;
    logic [ARM_W-1:0]      arm_cnt;
    logic [DATA_WIDTH-1:0] cyc_cnt;
    logic [DATA_WIDTH-1:0] period_q;
    logic [DATA_WIDTH-1:0] n_frames_q;
    logic [DATA_WIDTH-1:0] period_clamped;
    logic [DATA_WIDTH-1:0] index_next;
    logic                  last_cycle;
    logic                  final_frame;
    logic                  arm_last;

    // A period below 2 would make frame_start a constant level; clamp so it stays a strobe.
    assign period_clamped = (frame_period < DATA_WIDTH'(2)) ? DATA_WIDTH'(2) : frame_period;
    assign index_next     = frame_index + DATA_WIDTH'(1);
    assign last_cycle     = (cyc_cnt == period_q - DATA_WIDTH'(1));
    assign final_frame    = (n_frames_q != '0) && (index_next == n_frames_q);
    assign arm_last       = (arm_cnt == ARM_W'(ARM_CYCLES - 1));
    assign state          = st;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            st          <= ST_IDLE;
            acq_enable  <= 1'b0;
            frame_start <= 1'b0;
            frame_index <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            arm_cnt     <= '0;
            cyc_cnt     <= '0;
            period_q    <= '0;
            n_frames_q  <= '0;
        end else begin
            frame_start <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (run) begin
                        st          <= ST_ARM;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        period_q    <= period_clamped;
                        n_frames_q  <= n_frames;
                        frame_index <= '0;
                        cyc_cnt     <= '0;
                        arm_cnt     <= '0;
                    end
                end
                ST_ARM: begin
                    if (!run) begin
                        st <= ST_DRAIN;
                    end else if (arm_last) begin
                        st          <= ST_RUN;
                        acq_enable  <= 1'b1;
                        frame_start <= 1'b1;
                        cyc_cnt     <= '0;
                    end else begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end
                end
                ST_RUN: begin
                    // A frame whose last cycle coincides with run dropping still counts.
                    if (last_cycle) begin
                        frame_index <= index_next;
                    end
                    if ((last_cycle && final_frame) || !run) begin
                        st         <= ST_DRAIN;
                        acq_enable <= 1'b0;
                    end else begin
                        cyc_cnt     <= last_cycle ? '0 : cyc_cnt + DATA_WIDTH'(1);
                        frame_start <= last_cycle;
                    end
                end
                ST_DRAIN: begin
                    if (sink_idle) begin
                        st   <= ST_DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!run) begin
                        st   <= ST_IDLE;
                        done <= 1'b0;
                    end
                end
                default: begin
                    st         <= ST_IDLE;
                    acq_enable <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_run_ctrl.sv
// tb/tb_acq_run_ctrl.sv - self-checking bench for acq_run_ctrl
module tb_acq_run_ctrl;

    localparam int ARM = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [31:0] frame_period;
    logic [31:0] n_frames;
    logic        sink_idle;
    logic        acq_enable;
    logic        frame_start;
    logic [31:0] frame_index;
    logic        busy;
    logic        done;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int prev_idx = 0;

    acq_run_ctrl #(.DATA_WIDTH(32), .ARM_CYCLES(ARM)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (resetn),
        .run           (run),
        .frame_period  (frame_period),
        .n_frames      (n_frames),
        .sink_idle     (sink_idle),
        .acq_enable    (acq_enable),
        .frame_start   (frame_start),
        .frame_index   (frame_index),
        .busy          (busy),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int n;
        int u;
        int d;
        int e_acq;
        int e_idx;
        int e_done;
    } case_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {25'd0, state, acq_enable, frame_start, busy, done, frame_index};
    endfunction

    // One run started with run=1 in relative cycle 0; run held until cycle u (exclusive),
    // sink_idle held low for d cycles after DRAIN entry. Expected behaviour is derived
    // from the interval arithmetic of the timing rules.
    task automatic run_case(input string tag, input int p, input int n, input int u, input int d,
                            output int acq_n, output int idx_done, output int done_at);
        int pe, r, dr, dn, last, st_e, idx_e, cc;
        logic acq_e, fs_e;
        pe = (p < 2) ? 2 : p;
        r  = 1 + ARM;
        dr = u + 1;
        if (n != 0 && r + n * pe < dr) dr = r + n * pe;
        dn = dr + d + 1;
        last = ((dn > u) ? dn : u) + 1;
        acq_n = 0;
        idx_done = -1;
        done_at = -1;
        for (int c = 0; c <= last + 1; c++) begin
            if (c == 0)                 st_e = 0;
            else if (c < r && c < dr)   st_e = 1;
            else if (c < dr)            st_e = 2;
            else if (c < dn)            st_e = 3;
            else if (c <= last - 1)     st_e = 4;
            else                        st_e = 0;
            cc = (c < dr) ? c : dr;
            if (c == 0)      idx_e = prev_idx;
            else if (cc > r) idx_e = (cc - r) / pe;
            else             idx_e = 0;
            acq_e = (c >= r) && (c < dr);
            fs_e  = acq_e && (((c - r) % pe) == 0);
            check($sformatf("%s cyc%0d", tag, c), outs(),
                  {25'd0, 3'(st_e), acq_e, fs_e, (st_e >= 1 && st_e <= 3), (st_e == 4), 32'(idx_e)});
            acq_n += int'(acq_enable);
            if (done && done_at < 0) begin
                done_at  = c;
                idx_done = int'(frame_index);
            end
            run          = (c < u);
            frame_period = (c == 0) ? 32'(p) : $urandom;
            n_frames     = (c == 0) ? 32'(n) : $urandom;
            sink_idle    = !(c >= dr && c < dr + d);
            step();
        end
        prev_idx = idx_e;
    endtask

    initial begin
        case_t tbl[10];
        int acq_n, idx_d, done_at;
        tbl[0] = '{10,  3,  86,  0, 30,  3, 36};
        tbl[1] = '{100, 0, 255, 20, 251, 2, 277};
        tbl[2] = '{1,   2,  20,  0,  4,  2, 10};
        tbl[3] = '{0,   1,  15,  0,  2,  1,  8};
        tbl[4] = '{5,   0,  14,  2, 10,  2, 18};
        tbl[5] = '{5,   0,  13,  0,  9,  1, 15};
        tbl[6] = '{4,   2,   2,  1,  0,  0,  5};
        tbl[7] = '{3,   1,  30,  3,  3,  1, 12};
        tbl[8] = '{6,   2,   4,  0,  0,  0,  6};
        tbl[9] = '{7,   4,  80,  1, 28,  4, 35};

        resetn = 1'b0;
        run = 1'b1;
        frame_period = 32'd10;
        n_frames = 32'd0;
        sink_idle = 1'b1;

        repeat (3) begin
            step();
            check("reset_outs", outs(), 64'd0);
        end
        resetn = 1'b1;
        step();
        check("release_arm", {state, busy}, {3'd1, 1'b1});
        repeat (ARM) step();
        check("run_entry", {state, acq_enable, frame_start}, {3'd2, 1'b1, 1'b1});
        repeat (12) step();
        check("idx_mid_run", frame_index, 64'd1);
        resetn = 1'b0;
        step();
        check("reset_mid_run", outs(), 64'd0);
        resetn = 1'b1;
        step();
        check("restart_arm", {state, frame_index}, {3'd1, 32'd0});
        repeat (ARM) step();
        check("restart_run", {state, frame_start, frame_index}, {3'd2, 1'b1, 32'd0});
        run = 1'b0;
        step();
        check("abort_drain", {state, acq_enable, busy}, {3'd3, 1'b0, 1'b1});
        step();
        check("abort_done", {state, busy, done}, {3'd4, 1'b0, 1'b1});
        step();
        check("back_idle", {state, done}, {3'd0, 1'b0});
        prev_idx = 0;

        for (int i = 0; i < 10; i++) begin
            run_case($sformatf("tbl%0d", i), tbl[i].p, tbl[i].n, tbl[i].u, tbl[i].d,
                     acq_n, idx_d, done_at);
            check($sformatf("tbl%0d acq_cycles", i), 64'(acq_n), 64'(tbl[i].e_acq));
            check($sformatf("tbl%0d idx_at_done", i), 64'(idx_d), 64'(tbl[i].e_idx));
            check($sformatf("tbl%0d done_cycle", i), 64'(done_at), 64'(tbl[i].e_done));
        end

        for (int i = 0; i < 40; i++) begin
            run_case($sformatf("rnd%0d", i), int'($urandom_range(6, 0)), int'($urandom_range(4, 0)),
                     int'($urandom_range(60, 1)), int'($urandom_range(4, 0)), acq_n, idx_d, done_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_run_ctrl.md
# acq_run_ctrl

Acquisition run controller that consumes the `run` flag from the global config register block and converts it into a framed acquisition sequence. It sits directly downstream of the config registers in the `s_axi_aclk` domain. It arms the datapath, emits fixed-length frames with a frame-start strobe, and counts completed frames. It then drains, waiting for the downstream sink to go idle before reporting done.

## Interface
- `DATA_WIDTH`, 32, width of `frame_period`, `n_frames`, `frame_index`
- `ARM_CYCLES`, 4, cycles spent in ARM before the first frame (≥1)
- `s_axi_aclk` in 1: clock, shared with config registers
- `s_axi_aresetn` in 1: reset, synchronous, active-low
- `run` in 1: run request level from config flags
- `frame_period` in DATA_WIDTH: cycles per frame; 0 or 1 clamped to 2
- `n_frames` in DATA_WIDTH: frames per run; 0 = continuous
- `sink_idle` in 1: downstream pipeline empty
- `acq_enable` out 1: datapath acquisition enable
- `frame_start` out 1: one-cycle strobe on the first cycle of each frame
- `frame_index` out DATA_WIDTH: completed frames in the current/last run
- `busy` out 1: state is ARM, RUN or DRAIN
- `done` out 1: state is DONE
- `state` out 3: IDLE=0, ARM=1, RUN=2, DRAIN=3, DONE=4

## Operation
- All outputs are registered. Reset (`s_axi_aresetn`=0 at a clock edge) gives: state IDLE; all outputs 0; internal counters 0. Reset mid-run aborts immediately, with no drain.
- IDLE:
  - `run`=1 → ARM.
  - On ARM entry, latch `frame_period` (clamped) and `n_frames`, and clear `frame_index` and the cycle counter.
- ARM:
  - Count ARM_CYCLES cycles, then → RUN.
  - `run`=0 during ARM → DRAIN.
- RUN:
  - `acq_enable`=1.
  - The cycle counter runs 0..period-1 and wraps. `frame_start`=1 when the counter is 0.
  - On the last cycle of a frame (counter = period-1), `frame_index` increments; the new value is visible on the next cycle.
  - If `n_frames`≠0 and that increment makes `frame_index`=`n_frames` → DRAIN.
  - `run` sampled 0 → DRAIN; a partial frame is not counted.
  - If `run`=0 coincides with a last frame cycle, the frame is counted.
- DRAIN:
  - `acq_enable`=0, `frame_start`=0.
  - `sink_idle`=1 → DONE. The minimum dwell is 1 cycle and the maximum is unbounded.
- DONE:
  - `done`=1; `frame_index` is held.
  - `run`=0 → IDLE. While `run` stays 1, the block stays in DONE, so a new run requires `run` to toggle low.
- Changes to `frame_period`/`n_frames` after ARM entry are ignored until the next run.
- Continuous mode: `frame_index` wraps from 2^DATA_WIDTH-1 to 0 without leaving RUN.

## Timing
- `run` sampled 1 in IDLE at edge t → ARM at t+1, RUN at t+1+ARM_CYCLES.
- The first `frame_start` and the rising edge of `acq_enable` occur in the same cycle as RUN entry.
- With period P and N frames:
  - `acq_enable` is high for exactly N·P cycles.
  - `frame_start` pulses at RUN entry + k·P, for k=0..N-1.
- After the final frame, DRAIN is entered the next cycle. DONE follows one cycle after `sink_idle` is first sampled 1 in DRAIN.
- Abort: `run`=0 sampled in RUN at edge u → `acq_enable`=0 at u+1.
- `busy` and `done` are never both 1.

## Test plan
- Reset: hold `s_axi_aresetn` low 3 cycles with `run`=1 → all outputs 0, `state`=0. One cycle after release → `state`=1.
- Normal run, P=10, N=3, ARM_CYCLES=4, `sink_idle`=1, `run` high at t0:
  - `frame_start` at t0+5, t0+15, t0+25.
  - `acq_enable` high from t0+5 to t0+34.
  - DRAIN at t0+35, DONE at t0+36, `frame_index`=3.
- Abort, P=100, N=0:
  - Drop `run` 250 cycles after RUN entry → `acq_enable`=0 next cycle, `frame_index`=2.
  - Hold `sink_idle`=0 for 20 cycles → stays DRAIN; raise it → DONE one cycle later.
- Clamp, P=1, N=2 → `frame_start` every 2 cycles, `acq_enable` high for 4 cycles, `frame_index`=2.
- Reset mid-RUN → IDLE, outputs 0 at the next edge. With `run` still 1 after release, the run restarts with `frame_index`=0.
- Re-arm:
  - Hold `run` high after DONE for 50 cycles → stays DONE.
  - Drive `run` low then high → IDLE then ARM, `frame_index` cleared.
  - A change to `frame_period` mid-RUN does not alter the current frame spacing.
